// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, single-outstanding imem handshake and IF/ID register.
// Define IFETCH_MISALIGN_EN to flag misaligned redirect targets instead of truncating them.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcSel,
    input  logic [31:0] brTarget,
    input  logic [31:0] jTarget,
    input  logic        pcStall,
    input  logic        ifidStall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic [31:0] dinst,
    output logic [31:0] dpc,
    output logic        dvalid,
`ifdef IFETCH_MISALIGN_EN
    output logic        misalignFault,
`endif
    output logic [6:0]  funct7,
    output logic [4:0]  rs2,
    output logic [4:0]  rs1,
    output logic [2:0]  funct3,
    output logic [4:0]  rd,
    output logic [6:0]  opcode
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        BUFFERED
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dinst_q, dinst_d;
    logic [31:0] dpc_q, dpc_d;
    logic        dvalid_q, dvalid_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        discard_q, discard_d;

    logic        redirect;
    logic        halted;
    logic [31:0] target_raw;
    logic [31:0] target;

    assign redirect   = (pcSel == 2'b01) || (pcSel == 2'b10);
    assign target_raw = (pcSel == 2'b10) ? jTarget : brTarget;

`ifdef IFETCH_MISALIGN_EN
    logic fault_q;

    assign target        = target_raw;
    assign halted        = fault_q;
    assign misalignFault = fault_q;

    // Fault persists until the next redirect re-evaluates alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= |target_raw[1:0];
        end
    end
`else
    assign target = target_raw & ~32'h3;
    assign halted = 1'b0;
`endif

    always_comb begin
        imemReq = 1'b0;
        if (!rst) begin
            unique case (state_q)
                FETCH:   imemReq = !pcStall && !redirect && !halted;
                WAIT:    imemReq = !discard_q;
                default: imemReq = 1'b0;
            endcase
        end
    end

    assign imemAddr = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dinst_d    = dinst_q;
        dpc_d      = dpc_q;
        dvalid_d   = dvalid_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        discard_d  = discard_q;

        // Bubble into IF/ID unless stalled or a real instruction arrives.
        if (!ifidStall) begin
            dinst_d  = NOP_INST;
            dvalid_d = 1'b0;
        end

        if (redirect) begin
            pc_d       = target;
            dinst_d    = NOP_INST;
            dvalid_d   = 1'b0;
            buf_inst_d = '0;
            buf_pc_d   = '0;
            if (state_q == WAIT && !imemValid) begin
                state_d   = WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = FETCH;
                discard_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imemReq) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imemValid) begin
                        state_d   = FETCH;
                        discard_d = 1'b0;
                        if (!discard_q) begin
                            pc_d = pc_q + 32'd4;
                            if (ifidStall) begin
                                buf_inst_d = imemData;
                                buf_pc_d   = pc_q;
                                state_d    = BUFFERED;
                            end else begin
                                dinst_d  = imemData;
                                dpc_d    = pc_q;
                                dvalid_d = 1'b1;
                            end
                        end
                    end
                end
                BUFFERED: begin
                    if (!ifidStall) begin
                        dinst_d  = buf_inst_q;
                        dpc_d    = buf_pc_q;
                        dvalid_d = 1'b1;
                        state_d  = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            dinst_q    <= NOP_INST;
            dpc_q      <= '0;
            dvalid_q   <= 1'b0;
            buf_inst_q <= '0;
            buf_pc_q   <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dinst_q    <= dinst_d;
            dpc_q      <= dpc_d;
            dvalid_q   <= dvalid_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            discard_q  <= discard_d;
        end
    end

    assign dinst  = dinst_q;
    assign dpc    = dpc_q;
    assign dvalid = dvalid_q;
    assign funct7 = dinst_q[31:25];
    assign rs2    = dinst_q[24:20];
    assign rs1    = dinst_q[19:15];
    assign funct3 = dinst_q[14:12];
    assign rd     = dinst_q[11:7];
    assign opcode = dinst_q[6:0];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vectors, corner sequences
// and a random phase against a queue-based fetch/delivery model.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pcSel = 2'b00;
    logic [31:0] brTarget = '0;
    logic [31:0] jTarget = '0;
    logic        pcStall = 1'b0;
    logic        ifidStall = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid = 1'b0;
    logic [31:0] imemData = '0;
    logic [31:0] dinst;
    logic [31:0] dpc;
    logic        dvalid;
    logic [6:0]  funct7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;

    int checks = 0;
    int failures = 0;

    instruction_fetch_stage dut (
        .clk(clk), .rst(rst), .pcSel(pcSel),
        .brTarget(brTarget), .jTarget(jTarget),
        .pcStall(pcStall), .ifidStall(ifidStall),
        .imemReq(imemReq), .imemAddr(imemAddr),
        .imemValid(imemValid), .imemData(imemData),
        .dinst(dinst), .dpc(dpc), .dvalid(dvalid),
        .funct7(funct7), .rs2(rs2), .rs1(rs1),
        .funct3(funct3), .rd(rd), .opcode(opcode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Instruction memory contents
    bit [31:0] mem [bit [31:0]];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    // Memory responder and random-phase model state
    bit          busy = 0;
    bit          live = 0;
    int          cnt = 0;
    int          lat = 1;
    logic [31:0] maddr = '0;
    bit          rnd_en = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_dinst;
    logic [31:0] exp_dpc;
    logic        exp_dvalid;
    bit          dpc_known;
    int          ndeliv = 0;

    task automatic model_reset();
        exp_pc     = 32'h0;
        q.delete();
        exp_dinst  = NOP;
        exp_dpc    = 32'h0;
        exp_dvalid = 1'b0;
        dpc_known  = 1;
    endtask

    task automatic model_step();
        bit          redir;
        logic [31:0] tgt;
        ent_t        e;
        redir = (pcSel == 2'b01) || (pcSel == 2'b10);
        tgt   = ((pcSel == 2'b10) ? jTarget : brTarget) & ~32'h3;
        if (redir) begin
            exp_pc = tgt;
            q.delete();
            live       = 0;
            exp_dinst  = NOP;
            exp_dvalid = 1'b0;
            dpc_known  = 0;
        end else begin
            if (imemValid && live) begin
                q.push_back('{pc: maddr, inst: imemData});
                exp_pc = exp_pc + 32'd4;
            end
            if (!ifidStall) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    exp_dinst  = e.inst;
                    exp_dpc    = e.pc;
                    exp_dvalid = 1'b1;
                    dpc_known  = 1;
                    ndeliv++;
                end else begin
                    exp_dinst  = NOP;
                    exp_dvalid = 1'b0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                imemValid = 0;
                busy = 0;
                live = 0;
            end else if (imemValid) begin
                imemValid = 0;
                busy = 0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imemValid = 1;
                    imemData  = word_at(maddr);
                end
            end
            @(negedge clk);
            #1;
            if (rst) begin
                imemValid = 0;
                busy = 0;
                live = 0;
                model_reset();
            end else begin
                if (rnd_en) begin
                    logic er;
                    if (busy) er = live;
                    else if (q.size() > 0) er = 1'b0;
                    else er = !pcStall && !(pcSel == 2'b01 || pcSel == 2'b10);
                    chk("rnd_dinst", dinst, exp_dinst);
                    chk("rnd_dvalid", {31'b0, dvalid}, {31'b0, exp_dvalid});
                    if (dpc_known) chk("rnd_dpc", dpc, exp_dpc);
                    chk("rnd_fields", {funct7, rs2, rs1, funct3, rd, opcode}, exp_dinst);
                    chk("rnd_imemReq", {31'b0, imemReq}, {31'b0, er});
                end
                if (!busy && imemReq) begin
                    if (rnd_en) chk("rnd_imemAddr", imemAddr, exp_pc);
                    busy  = 1;
                    live  = 1;
                    maddr = imemAddr;
                    cnt   = rnd_en ? int'($urandom_range(3, 1)) : lat;
                end
                if (rnd_en) model_step();
            end
        end
    end

    task automatic wait_delivery(input logic [31:0] pc, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dvalid && dpc == pc) && n < 40);
        checks++;
        if (!(dvalid && dpc == pc)) begin
            failures++;
            $display("FAIL %s: dpc=%h dvalid=%0b, expected delivery of pc %h", name, dpc, dvalid, pc);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imemReq && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!imemReq) begin
            failures++;
            $display("FAIL %s: imemReq=0 expected 1 within %0d cycles", name, n);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        pcSel = 2'b00;
        pcStall = 0;
        ifidStall = 0;
        lat = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  f7;
        logic [4:0]  r2;
        logic [4:0]  r1;
        logic [2:0]  f3;
        logic [4:0]  rdx;
        logic [6:0]  op;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0, 32'h00500093, 7'h00, 5'd5, 5'd0, 3'd0, 5'd1, 7'h13, 32'h4};
        tbl[1] = '{32'h4, 32'h40208233, 7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33, 32'h8};
        tbl[2] = '{32'h8, 32'h002081B3, 7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33, 32'hC};
        tbl[3] = '{32'hC, 32'h0000A283, 7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03, 32'h10};
        for (int i = 0; i < 4; i++) mem[tbl[i].pc] = tbl[i].inst;
        mem[32'h40] = 32'h00100113;

        // Reset state and straight-line fetch
        repeat (2) @(negedge clk);
        chk("rst_imemReq", {31'b0, imemReq}, 32'h0);
        chk("rst_dinst", dinst, NOP);
        chk("rst_dpc", dpc, 32'h0);
        chk("rst_dvalid", {31'b0, dvalid}, 32'h0);
        rst = 0;
        #1;
        chk("first_req", {31'b0, imemReq}, 32'h1);
        chk("first_addr", imemAddr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_delivery(tbl[i].pc, "tbl_deliver");
            chk("tbl_dinst", dinst, tbl[i].inst);
            chk("tbl_funct7", {25'b0, funct7}, {25'b0, tbl[i].f7});
            chk("tbl_rs2", {27'b0, rs2}, {27'b0, tbl[i].r2});
            chk("tbl_rs1", {27'b0, rs1}, {27'b0, tbl[i].r1});
            chk("tbl_funct3", {29'b0, funct3}, {29'b0, tbl[i].f3});
            chk("tbl_rd", {27'b0, rd}, {27'b0, tbl[i].rdx});
            chk("tbl_opcode", {25'b0, opcode}, {25'b0, tbl[i].op});
            chk("tbl_next_req", {31'b0, imemReq}, 32'h1);
            chk("tbl_next_addr", imemAddr, tbl[i].nxt);
        end

        // IF/ID stall across a response: word parks in the buffer
        do_reset();
        wait_delivery(32'h4, "stall_pre");
        ifidStall = 1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("stall_hold_dinst", dinst, 32'h40208233);
            chk("stall_hold_dpc", dpc, 32'h4);
            chk("stall_hold_dvalid", {31'b0, dvalid}, 32'h1);
            chk("stall_no_req", {31'b0, imemReq}, 32'h0);
            @(negedge clk);
        end
        ifidStall = 0;
        @(negedge clk);
        chk("stall_rel_dinst", dinst, 32'h002081B3);
        chk("stall_rel_dpc", dpc, 32'h8);
        chk("stall_rel_dvalid", {31'b0, dvalid}, 32'h1);
        chk("stall_rel_req", {31'b0, imemReq}, 32'h1);
        chk("stall_rel_addr", imemAddr, 32'hC);

        // Branch redirect while a slow fetch is outstanding
        do_reset();
        wait_delivery(32'hC, "redir_pre");
        lat = 3;
        @(negedge clk);
        pcSel = 2'b01;
        brTarget = 32'h40;
        @(negedge clk);
        pcSel = 2'b00;
        chk("redir_dvalid", {31'b0, dvalid}, 32'h0);
        chk("redir_dinst", dinst, NOP);
        chk("redir_req_low", {31'b0, imemReq}, 32'h0);
        wait_req("redir_refetch");
        lat = 1;
        chk("redir_addr", imemAddr, 32'h40);
        chk("redir_dropped_dvalid", {31'b0, dvalid}, 32'h0);
        chk("redir_dropped_dinst", dinst, NOP);
        wait_delivery(32'h40, "redir_deliver");
        chk("redir_target_inst", dinst, 32'h00100113);

        // pcStall held in FETCH
        rst = 1;
        pcSel = 2'b00;
        ifidStall = 0;
        pcStall = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("pcstall_req", {31'b0, imemReq}, 32'h0);
            chk("pcstall_dvalid", {31'b0, dvalid}, 32'h0);
            @(negedge clk);
        end
        pcStall = 0;
        #1;
        chk("pcstall_resume_req", {31'b0, imemReq}, 32'h1);
        chk("pcstall_resume_addr", imemAddr, 32'h0);
        wait_delivery(32'h0, "pcstall_deliver");
        chk("pcstall_inst", dinst, 32'h00500093);

        // PC wrap at the top of the address space
        rst = 1;
        pcStall = 0;
        pcSel = 2'b10;
        jTarget = 32'hFFFF_FFFC;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("wrap_redir_no_req", {31'b0, imemReq}, 32'h0);
        @(negedge clk);
        pcSel = 2'b00;
        wait_delivery(32'hFFFF_FFFC, "wrap_deliver");
        chk("wrap_inst", dinst, word_at(32'hFFFF_FFFC));
        chk("wrap_req", {31'b0, imemReq}, 32'h1);
        chk("wrap_addr", imemAddr, 32'h0);

        // Random phase against the reference model
        rnd_en = 1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(posedge clk);
            #1;
            r = int'($urandom % 100);
            if (r < 6) pcSel = 2'b01;
            else if (r < 12) pcSel = 2'b10;
            else if (r < 15) pcSel = 2'b11;
            else pcSel = 2'b00;
            brTarget  = $urandom;
            jTarget   = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            pcStall   = ($urandom % 100) < 20;
            ifidStall = ($urandom % 100) < 25;
        end
        @(posedge clk);
        #1;
        rnd_en = 0;
        pcSel = 2'b00;
        chk("rnd_deliveries", {31'b0, ndeliv > 50}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
